heap_sched: RTL and testbench
=============================

HEAP_SCHED -- requirements
Module: heap_sched

Interface
REQ-001 Parameter BITS, default 2: key width.
REQ-002 Parameter WORDS, default 4: heap capacity, informational only.
REQ-003 Parameter TEST_PERIOD, default 64: cycles between scrub TEST commands; 0 disables scrubbing.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 req  in  2  request, one bit per requester, bit i belongs to requester i.
REQ-007 op0, op1  in  2 each  requested command: NOOP=0, PUSH=1, POP=2, TEST=3.
REQ-008 din0, din1  in  BITS each  key to push.
REQ-009 ack  out  2  one-cycle completion pulse to the granted requester.
REQ-010 rok  out  1  result-ok flag, valid while any ack bit is high.
REQ-011 rdata  out  BITS  popped minimum key, valid with ack when the completed op was POP and rok=1.
REQ-012 h_cmd  out  2  command to the heap.
REQ-013 h_din  out  BITS  key to the heap.
REQ-014 h_dout  in  BITS  heap minimum key.
REQ-015 h_ready, h_full, h_empty, h_error  in  1 each  heap status inputs.
REQ-016 err_flag  out  1  sticky flag, set when a scrub TEST reports error.

Function
REQ-017 Handshake: requester i holds req[i], op_i and din_i stable until ack[i] pulses; it may then drop req[i] or present the next op.
REQ-018 FSM states and transitions:
- S_IDLE: waits for h_ready=1 and a candidate, then latches op and din and goes to S_ISSUE or S_DONE.
- S_ISSUE: one cycle, then S_WAIT.
- S_WAIT: held until h_ready=1, then S_DONE.
- S_DONE: one cycle, then S_IDLE.
REQ-019 Candidate priority in S_IDLE: a pending scrub first, then round-robin among asserted req bits; the pointer resets to favour requester 0 and moves past the winner in S_DONE.
REQ-020 Latched PUSH with h_full=1, or POP with h_empty=1, is rejected: S_IDLE -> S_DONE, rok=0, h_cmd stays NOOP.
REQ-021 Latched NOOP goes S_IDLE -> S_DONE with rok=1 and no heap command.
REQ-022 h_cmd equals the latched op only in S_ISSUE and is NOOP in every other state; h_din equals the latched din in S_ISSUE.
REQ-023 For POP, rdata captures h_dout in S_ISSUE.
REQ-024 For TEST, h_error is sampled on the S_WAIT -> S_DONE edge; rok = !h_error, and err_flag sets if h_error=1.
REQ-025 ack[i] is high only during S_DONE of a requester-initiated op; scrub ops produce no ack.
REQ-026 Latencies, with request sampled in S_IDLE at cycle t:
- Rejected or NOOP op: ack at t+1.
- Issued op: ack one cycle after the first cycle of S_WAIT in which h_ready=1.
REQ-027 Scrub counter counts up each cycle and sets scrub_pend when it reaches TEST_PERIOD-1, then wraps to 0.
REQ-028 scrub_pend clears when its TEST is latched; a second expiry while pending is absorbed.
REQ-029 Requests arriving mid-operation wait; simultaneous req bits are served in consecutive operations, one per S_IDLE pass.

Reset
REQ-030 On reset_n=0, immediately:
- State = S_IDLE.
- ack=0, rok=0, rdata=0, err_flag=0.
- h_cmd=NOOP, h_din=0.
- Scrub counter 0, scrub_pend 0, round-robin pointer 0.
REQ-031 Reset asserted mid-operation abandons the op with no ack; after release, nothing issues until h_ready=1, because the heap has no reset.
REQ-032 err_flag clears only on reset.

Structure
REQ-033 Shared package heap_pkg holds the op codes NOOP, PUSH, POP, TEST and the heap_sched state encoding.
REQ-034 One sub-module, heap_rr_arb, holds the 2-way round-robin grant logic with its pointer.

Verification
REQ-035 Bench pairs heap_sched with the heap model, BITS=2, WORDS=4, TEST_PERIOD=0 unless stated.
REQ-036 Req0 pushes 3, 1, 2, then POPs -> one ack per op, rok=1, POP returns rdata=1, and a second POP returns rdata=2.
REQ-037 After reset, req=2'b11 with op0=PUSH 2 and op1=PUSH 0 -> ack0 first, then ack1, then a req0 POP returns rdata=0.
REQ-038 POP on the empty heap -> ack at t+1, rok=0, h_cmd never leaves NOOP; PUSH on a full heap (4 items) -> same response.
REQ-039 TEST_PERIOD=16 with the heap idle -> h_cmd=TEST within 17 cycles, no ack, err_flag stays 0; forcing h_error=1 sets err_flag and it holds until reset.
REQ-040 reset_n pulsed low during S_WAIT of a PUSH -> no ack; after release, no issue until h_ready=1, then a following POP returns the pushed key.

Source files
------------

// File: rtl/heap_pkg.sv
// heap_pkg: shared definitions for the heap scheduler slice.
//   heap_op_e     - command codes exchanged with requesters and the heap
//   sched_state_e - heap_sched controller states
package heap_pkg;

  typedef enum logic [1:0] {
    NOOP = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    TEST = 2'd3
  } heap_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/heap_rr_arb.sv
// heap_rr_arb: 2-way round-robin grant for heap_sched.
//   clk_i, rst_ni  - clock, async active-low reset (pointer favours requester 0)
//   req_i          - asserted request bits
//   adv_i          - pulse when the granted op completes; moves pointer past adv_idx_i
//   adv_idx_i      - index of the requester that just completed
//   gnt_valid_o    - any request present
//   gnt_idx_o      - winning requester index
module heap_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  input  logic       adv_idx_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic ptr_q;

  // The pointer names the requester with priority this round.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = req_i[ptr_q] ? ptr_q : ~ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (adv_i) begin
      ptr_q <= ~adv_idx_i;
    end
  end

endmodule

// File: rtl/heap_sched.sv
// heap_sched: arbitrates two requesters plus a periodic scrub TEST onto a
// single heap command port.
//   clock, reset_n         - clock, async active-low reset
//   req, op0/op1, din0/din1- requester handshake (held until ack)
//   ack, rok, rdata        - completion pulse, result-ok, popped key
//   h_cmd, h_din           - command/key to the heap (driven only in S_ISSUE)
//   h_dout, h_ready, h_full, h_empty, h_error - heap status
//   err_flag               - sticky scrub error
module heap_sched
  import heap_pkg::*;
#(
  parameter int BITS        = 2,
  parameter int WORDS       = 4,
  parameter int TEST_PERIOD = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      req,
  input  logic [1:0]      op0,
  input  logic [1:0]      op1,
  input  logic [BITS-1:0] din0,
  input  logic [BITS-1:0] din1,
  output logic [1:0]      ack,
  output logic            rok,
  output logic [BITS-1:0] rdata,
  output logic [1:0]      h_cmd,
  output logic [BITS-1:0] h_din,
  input  logic [BITS-1:0] h_dout,
  input  logic            h_ready,
  input  logic            h_full,
  input  logic            h_empty,
  input  logic            h_error,
  output logic            err_flag
);

  if (WORDS < 1) begin : g_cfg_check
    $error("heap_sched: WORDS must be at least 1");
  end

  localparam int          CW       = (TEST_PERIOD > 1) ? $clog2(TEST_PERIOD) : 1;
  localparam logic        SCRUB_EN = (TEST_PERIOD > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TEST_PERIOD > 0) ? TEST_PERIOD - 1 : 0);

  sched_state_e    state_q;
  heap_op_e        op_q;
  heap_op_e        h_cmd_q;
  logic [BITS-1:0] din_q, h_din_q, rdata_q;
  logic            scrub_q, idx_q;
  logic [1:0]      ack_q;
  logic            rok_q, err_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_set;

  logic            gnt_valid, gnt_idx;
  logic            cand_valid, cand_scrub, cand_reject;
  heap_op_e        cand_op;
  logic [BITS-1:0] cand_din;

  heap_rr_arb u_arb (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .req_i       (req),
    .adv_i       ((state_q == S_DONE) && !scrub_q),
    .adv_idx_i   (idx_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    pend_set    = SCRUB_EN && (cnt_q == CNT_LAST);
    cnt_d       = (!SCRUB_EN || pend_set) ? '0 : cnt_q + 1'b1;
    cand_valid  = pend_q || gnt_valid;
    cand_scrub  = pend_q;
    cand_op     = pend_q ? TEST : heap_op_e'(gnt_idx ? op1 : op0);
    cand_din    = pend_q ? '0 : (gnt_idx ? din1 : din0);
    cand_reject = ((cand_op == PUSH) && h_full) || ((cand_op == POP) && h_empty);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= NOOP;
      din_q   <= '0;
      scrub_q <= 1'b0;
      idx_q   <= 1'b0;
      ack_q   <= '0;
      rok_q   <= 1'b0;
      rdata_q <= '0;
      h_cmd_q <= NOOP;
      h_din_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ack_q   <= '0;
      rok_q   <= 1'b0;
      h_cmd_q <= NOOP;
      h_din_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (h_ready && cand_valid) begin
            op_q    <= cand_op;
            din_q   <= cand_din;
            scrub_q <= cand_scrub;
            idx_q   <= gnt_idx;
            if (cand_scrub) pend_q <= 1'b0;
            // Rejects and NOOPs complete without touching the heap.
            if (cand_reject || (cand_op == NOOP)) begin
              state_q <= S_DONE;
              rok_q   <= !cand_reject;
              if (!cand_scrub) ack_q[gnt_idx] <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              h_cmd_q <= cand_op;
              h_din_q <= cand_din;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          if (op_q == POP) rdata_q <= h_dout;
        end
        S_WAIT: begin
          if (h_ready) begin
            state_q <= S_DONE;
            rok_q   <= (op_q == TEST) ? !h_error : 1'b1;
            if ((op_q == TEST) && h_error) err_q <= 1'b1;
            if (!scrub_q) ack_q[idx_q] <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // An expiry coinciding with the latch of the previous TEST re-arms.
      if (pend_set) pend_q <= 1'b1;
    end
  end

  assign ack      = ack_q;
  assign rok      = rok_q;
  assign rdata    = rdata_q;
  assign h_cmd    = h_cmd_q;
  assign h_din    = h_din_q;
  assign err_flag = err_q;

endmodule

// File: tb/tb_heap_sched.sv
// tb_heap_sched: scoreboard bench for heap_sched with a behavioural heap
// (no reset, configurable busy latency) and a second instance for scrubbing.
module tb_heap_sched;
  import heap_pkg::*;

  logic       clock;
  logic       reset_n, rst_s_n;
  logic [1:0] req, op0, op1, din0, din1;
  logic [1:0] ack, rdata, h_cmd, h_din;
  logic       rok, err_flag;
  logic [1:0] h_dout  = 2'd0;
  logic       h_full  = 1'b0;
  logic       h_empty = 1'b1;
  logic       h_error = 1'b0;
  logic       h_ready;

  logic [1:0] req_s, op_s, din_s, ack_s, rdata_s, h_cmd_s, h_din_s, h_dout_s;
  logic       rok_s, err_s, h_error_s, h_ready_s, h_full_s, h_empty_s;

  heap_sched #(.BITS(2), .WORDS(4), .TEST_PERIOD(0)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op0(op0), .op1(op1),
    .din0(din0), .din1(din1), .ack(ack), .rok(rok), .rdata(rdata),
    .h_cmd(h_cmd), .h_din(h_din), .h_dout(h_dout), .h_ready(h_ready),
    .h_full(h_full), .h_empty(h_empty), .h_error(h_error), .err_flag(err_flag)
  );

  heap_sched #(.BITS(2), .WORDS(4), .TEST_PERIOD(16)) dut_s (
    .clock(clock), .reset_n(rst_s_n), .req(req_s), .op0(op_s), .op1(op_s),
    .din0(din_s), .din1(din_s), .ack(ack_s), .rok(rok_s), .rdata(rdata_s),
    .h_cmd(h_cmd_s), .h_din(h_din_s), .h_dout(h_dout_s), .h_ready(h_ready_s),
    .h_full(h_full_s), .h_empty(h_empty_s), .h_error(h_error_s), .err_flag(err_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Heap model: sorted queue, min at the front, busy for hlat cycles per command.
  logic [1:0] hq[$];
  int         busy = 0;
  int         hlat = 2;
  assign h_ready = (busy == 0);

  always @(posedge clock) begin
    if (h_cmd == PUSH) begin
      hq.push_back(h_din);
      hq.sort();
    end else if (h_cmd == POP && hq.size() > 0) begin
      void'(hq.pop_front());
    end
    if (h_cmd != NOOP) busy <= hlat;
    else if (busy > 0) busy <= busy - 1;
    h_dout  <= (hq.size() > 0) ? hq[0] : 2'd0;
    h_full  <= (hq.size() >= 4);
    h_empty <= (hq.size() == 0);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue bookkeeping: heap commands seen, commands issued while heap busy, scrub acks.
  int   cmd_cnt = 0, busy_viol = 0, ack_s_cnt = 0;
  logic prev_ready = 1'b1;
  always @(posedge clock) begin
    if (h_cmd != NOOP) begin
      cmd_cnt++;
      if (!prev_ready) busy_viol++;
    end
    prev_ready = h_ready;
    if (ack_s != 2'b00) ack_s_cnt++;
  end

  typedef struct {
    logic [1:0] ack;
    logic       rok;
    logic       chk_data;
    logic [1:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Monitor: every ack pulse consumes the oldest expectation.
  always @(negedge clock) begin
    if (ack !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", ack, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_owner", ack, mon_e.ack);
        check("rok", rok, mon_e.rok);
        if (mon_e.chk_data) check("rdata", rdata, mon_e.data);
      end
    end
  end

  task automatic expect_ack(input int idx, input logic r, input logic cd, input logic [1:0] d);
    exp_t e;
    e.ack = (idx == 0) ? 2'b01 : 2'b10;
    e.rok = r;
    e.chk_data = cd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int idx, output int cyc);
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
    end while (ack[idx] !== 1'b1 && cyc < 200);
    if (ack[idx] !== 1'b1) check("ack_timeout", 0, 1);
  endtask

  task automatic do_op(input int idx, input logic [1:0] op, input logic [1:0] din,
                       input logic r, input logic cd, input logic [1:0] d, input logic chk_lat);
    int cyc;
    expect_ack(idx, r, cd, d);
    @(negedge clock);
    if (idx == 0) begin op0 = op; din0 = din; end
    else          begin op1 = op; din1 = din; end
    req[idx] = 1'b1;
    wait_ack(idx, cyc);
    if (chk_lat) check("reject_latency", cyc, 1);
    @(negedge clock);
    req[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, cyc;
    logic found;
    reset_n = 1'b0; rst_s_n = 1'b0;
    req = 2'b00; op0 = NOOP; op1 = NOOP; din0 = 2'd0; din1 = 2'd0;
    req_s = 2'b00; op_s = NOOP; din_s = 2'd0; h_dout_s = 2'd0;
    h_ready_s = 1'b1; h_full_s = 1'b0; h_empty_s = 1'b0; h_error_s = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ack", ack, 0);
    check("rst_rok", rok, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err_flag, 0);
    check("rst_hcmd", h_cmd, NOOP);
    check("rst_hdin", h_din, 0);
    check("rst_s_rok", rok_s, 0);
    @(negedge clock) reset_n = 1'b1;

    // Push 3,1,2 then pop returns the minimum each time.
    do_op(0, PUSH, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0);
    do_op(0, PUSH, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0);
    do_op(0, PUSH, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0);
    do_op(0, POP,  2'd0, 1'b1, 1'b1, 2'd1, 1'b0);
    do_op(0, POP,  2'd0, 1'b1, 1'b1, 2'd2, 1'b0);
    do_op(0, POP,  2'd0, 1'b1, 1'b1, 2'd3, 1'b0);

    // POP on empty heap is rejected without a heap command.
    c0 = cmd_cnt;
    do_op(0, POP, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("empty_pop_no_cmd", cmd_cnt - c0, 0);

    // NOOP completes in one cycle with rok=1.
    c0 = cmd_cnt;
    do_op(1, NOOP, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1);
    check("noop_no_cmd", cmd_cnt - c0, 0);

    // Fill to four, then PUSH is rejected.
    do_op(1, PUSH, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0);
    do_op(1, PUSH, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    do_op(0, PUSH, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0);
    do_op(1, PUSH, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0);
    c0 = cmd_cnt;
    do_op(1, PUSH, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1);
    check("full_push_no_cmd", cmd_cnt - c0, 0);

    // Drain; last winner is requester 0, leaving the pointer on requester 1.
    do_op(1, POP, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    do_op(0, POP, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0);
    do_op(1, POP, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0);
    do_op(0, POP, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0);

    // After reset the pointer favours requester 0 on simultaneous requests.
    @(negedge clock) reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    expect_ack(0, 1'b1, 1'b0, 2'd0);
    expect_ack(1, 1'b1, 1'b0, 2'd0);
    @(negedge clock);
    op0 = PUSH; din0 = 2'd2; op1 = PUSH; din1 = 2'd0; req = 2'b11;
    wait_ack(0, cyc);
    @(negedge clock) req[0] = 1'b0;
    wait_ack(1, cyc);
    @(negedge clock) req[1] = 1'b0;
    do_op(0, POP, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    do_op(0, POP, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0);

    // Reset during S_WAIT of a PUSH: no ack, nothing issues while heap busy.
    hlat = 6;
    @(negedge clock);
    op0 = PUSH; din0 = 2'd3; req = 2'b01;
    cyc = 0;
    while (h_cmd !== PUSH && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("push_issued", h_cmd, PUSH);
    @(negedge clock);
    reset_n = 1'b0; req = 2'b00;
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_hcmd", h_cmd, NOOP);
    @(negedge clock) reset_n = 1'b1;
    check("heap_busy_after_rst", h_ready, 0);
    hlat = 2;
    do_op(0, POP, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0);

    // Scrub instance: TEST appears within 17 cycles, no ack, err_flag sticky.
    @(negedge clock) rst_s_n = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clock); #1;
      if (h_cmd_s == TEST) begin
        found = 1'b1;
        break;
      end
    end
    check("scrub_test_cmd", found, 1);
    check("scrub_din", h_din_s, 0);
    repeat (40) @(negedge clock);
    check("scrub_err_clear", err_s, 0);
    h_error_s = 1'b1;
    repeat (40) @(negedge clock);
    check("scrub_err_set", err_s, 1);
    h_error_s = 1'b0;
    repeat (40) @(negedge clock);
    check("scrub_err_sticky", err_s, 1);
    check("scrub_no_ack", ack_s_cnt, 0);
    check("scrub_rdata", rdata_s, 0);
    rst_s_n = 1'b0;
    #1;
    check("scrub_err_rst", err_s, 0);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("issue_while_busy", busy_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
